// File: rtl/bm_param_multiply_pipe_if.sv
// Beat and result bus of the parametrised multiply pipeline.
// The source side (master) offers operand beats and accepts results; the pipeline is the slave.
interface bm_param_multiply_pipe_if #(
    parameter int WA    = 8,
    parameter int WB    = 8,
    parameter int GUARD = 4
);
    localparam int R = WA + WB + GUARD;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [WA-1:0] a_in;
    logic [WB-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [R-1:0]  out_data;
    logic [R-1:0]  acc_value;

    modport master (
        output in_valid, in_op, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_data, acc_value
    );

    modport slave (
        input  in_valid, in_op, a_in, b_in, out_ready,
        output in_ready, out_valid, out_data, acc_value
    );
endinterface

// File: rtl/bm_param_multiply_pipe.sv
// Pipelined A*B datapath with MUL / ACC / LOAD / LOGIC opcodes, configurable depth
// and a single global stall driven by the output handshake.
module bm_param_multiply_pipe #(
    parameter int WA        = 8,
    parameter int WB        = 8,
    parameter int STAGES    = 3,
    parameter int GUARD     = 4,
    parameter bit LOGIC_AND = 1'b1
) (
    input logic                  clock,
    input logic                  reset,
    bm_param_multiply_pipe_if.slave bus
);
    localparam int WP = WA + WB;
    localparam int R  = WP + GUARD;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_ACC   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_LOGIC = 2'b11
    } op_e;

    logic          en;
    logic [WA-1:0] b_ext;
    logic [WP-1:0] entry_prod;
    logic [WA-1:0] entry_logic;

    logic          last_valid;
    op_e           last_op;
    logic [WP-1:0] last_prod;
    logic [WA-1:0] last_logic;

    logic          out_valid_q;
    logic [R-1:0]  out_data_q;
    logic [R-1:0]  acc_q;
    logic [R-1:0]  prod_ext;
    logic [R-1:0]  acc_sum;

    // Handshake: a beat transfers on in_valid & in_ready, a result on out_valid & out_ready.
    // The whole pipe moves together whenever the output register is empty or being drained.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    assign b_ext       = WA'(bus.b_in);
    assign entry_prod  = WP'(bus.a_in) * WP'(bus.b_in);
    assign entry_logic = LOGIC_AND ? (bus.a_in & b_ext) : (bus.a_in | b_ext);

    generate
        if (STAGES == 1) begin : g_direct
            assign last_valid = bus.in_valid;
            assign last_op    = op_e'(bus.in_op);
            assign last_prod  = entry_prod;
            assign last_logic = entry_logic;
        end else begin : g_pipe
            logic [STAGES-2:0] s_valid;
            op_e               s_op    [STAGES-1];
            logic [WP-1:0]     s_prod  [STAGES-1];
            logic [WA-1:0]     s_logic [STAGES-1];

            always_ff @(posedge clock) begin
                if (reset) begin
                    s_valid <= '0;
                end else if (en) begin
                    s_valid[0] <= bus.in_valid;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        s_valid[i] <= s_valid[i-1];
                    end
                end
            end

            // Payload needs no reset: it is only ever consumed behind a valid bit.
            always_ff @(posedge clock) begin
                if (en) begin
                    s_op[0]    <= op_e'(bus.in_op);
                    s_prod[0]  <= entry_prod;
                    s_logic[0] <= entry_logic;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        s_op[i]    <= s_op[i-1];
                        s_prod[i]  <= s_prod[i-1];
                        s_logic[i] <= s_logic[i-1];
                    end
                end
            end

            assign last_valid = s_valid[STAGES-2];
            assign last_op    = s_op[STAGES-2];
            assign last_prod  = s_prod[STAGES-2];
            assign last_logic = s_logic[STAGES-2];
        end
    endgenerate

    assign prod_ext = R'(last_prod);
    assign acc_sum  = acc_q + prod_ext;

    // The accumulator is read and written in the same stage, so back-to-back ACC beats chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
        end else if (en) begin
            out_valid_q <= last_valid;
            if (last_valid) begin
                case (last_op)
                    OP_MUL: out_data_q <= prod_ext;
                    OP_ACC: begin
                        acc_q      <= acc_sum;
                        out_data_q <= acc_sum;
                    end
                    OP_LOAD: begin
                        acc_q      <= prod_ext;
                        out_data_q <= prod_ext;
                    end
                    default: out_data_q <= R'(last_logic);
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.acc_value = acc_q;
endmodule
